// File: rtl/bus_arbiter_2dev.sv
// Two-device round-robin bus arbiter: registered select/grants, bounded hold
// under contention, and optional turnaround idle cycles between owners.
module bus_arbiter_2dev #(
    parameter int MAX_HOLD   = 4,
    parameter int TURNAROUND = 1,
    parameter int CNT_W      = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_1,
    input  logic req_2,
    input  logic done_1,
    input  logic done_2,
    output logic select,
    output logic gnt_1,
    output logic gnt_2,
    output logic bus_valid,
    output logic preempt
);

    typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, TURN} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] TURN_INIT = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    localparam bit               ZERO_TURN = (TURNAROUND == 0);

    state_t           r_state;
    logic             r_select;
    logic             r_gnt_1;
    logic             r_gnt_2;
    logic             r_preempt;
    logic             r_last_dev2;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] r_turn_cnt;

    logic w_granted;
    logic w_own_req;
    logic w_own_done;
    logic w_oth_req;
    logic w_release;
    logic w_hold_hit;
    logic w_leave;
    logic w_arbitrate;
    logic w_pick_valid;
    logic w_pick_dev2;

    always_comb begin
        w_granted    = (r_state == GRANT1) || (r_state == GRANT2);
        w_own_req    = (r_state == GRANT2) ? req_2  : req_1;
        w_own_done   = (r_state == GRANT2) ? done_2 : done_1;
        w_oth_req    = (r_state == GRANT2) ? req_1  : req_2;
        w_release    = w_granted && (w_own_done || !w_own_req);
        w_hold_hit   = w_granted && !w_release && w_oth_req && (r_hold_cnt == HOLD_LAST);
        w_leave      = w_release || w_hold_hit;
        // With no turnaround the release edge doubles as the arbitration edge.
        w_arbitrate  = (r_state == IDLE) || ((r_state == TURN) && (r_turn_cnt == '0))
                       || (w_leave && ZERO_TURN);
        w_pick_valid = req_1 || req_2;
        w_pick_dev2  = req_2 && (!req_1 || !r_last_dev2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_select    <= 1'b0;
            r_gnt_1     <= 1'b0;
            r_gnt_2     <= 1'b0;
            r_preempt   <= 1'b0;
            r_last_dev2 <= 1'b1;
            r_hold_cnt  <= '0;
            r_turn_cnt  <= '0;
        end else begin
            r_preempt <= w_hold_hit;
            if (w_arbitrate) begin
                if (w_pick_valid) begin
                    r_state     <= w_pick_dev2 ? GRANT2 : GRANT1;
                    r_gnt_1     <= !w_pick_dev2;
                    r_gnt_2     <= w_pick_dev2;
                    r_select    <= w_pick_dev2;
                    r_last_dev2 <= w_pick_dev2;
                    r_hold_cnt  <= '0;
                end else begin
                    r_state <= IDLE;
                    r_gnt_1 <= 1'b0;
                    r_gnt_2 <= 1'b0;
                end
            end else if (w_leave) begin
                r_state    <= TURN;
                r_gnt_1    <= 1'b0;
                r_gnt_2    <= 1'b0;
                r_turn_cnt <= TURN_INIT;
            end else begin
                case (r_state)
                    TURN:    r_turn_cnt <= r_turn_cnt - CNT_W'(1);
                    GRANT1,
                    GRANT2:  r_hold_cnt <= w_oth_req ? (r_hold_cnt + CNT_W'(1)) : '0;
                    default: r_hold_cnt <= r_hold_cnt;
                endcase
            end
        end
    end

    assign select    = r_select;
    assign gnt_1     = r_gnt_1;
    assign gnt_2     = r_gnt_2;
    assign bus_valid = r_gnt_1 | r_gnt_2;
    assign preempt   = r_preempt;

endmodule

// File: tb/tb_bus_arbiter_2dev.sv
// Bench for bus_arbiter_2dev: default instance (hold 4, turnaround 1) and a
// fast-swap instance (hold 2, no turnaround), driven from per-cycle vector tables.
module tb_bus_arbiter_2dev;

    typedef struct {
        logic [4:0] exp;   // {gnt_1, gnt_2, select, preempt, bus_valid}
        int         dut;
        int         idx;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_req_1 = 1'b0, a_req_2 = 1'b0, a_done_1 = 1'b0, a_done_2 = 1'b0;
    logic b_req_1 = 1'b0, b_req_2 = 1'b0, b_done_1 = 1'b0, b_done_2 = 1'b0;
    logic a_select, a_gnt_1, a_gnt_2, a_bus_valid, a_preempt;
    logic b_select, b_gnt_1, b_gnt_2, b_bus_valid, b_preempt;

    int errors = 0;
    int checks = 0;
    int vec_idx = 0;
    logic [7:0] seq[$];
    sb_t sb[$];

    always #5 clk = ~clk;

    bus_arbiter_2dev #(.MAX_HOLD(4), .TURNAROUND(1), .CNT_W(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_1(a_req_1), .req_2(a_req_2), .done_1(a_done_1), .done_2(a_done_2),
        .select(a_select), .gnt_1(a_gnt_1), .gnt_2(a_gnt_2),
        .bus_valid(a_bus_valid), .preempt(a_preempt)
    );

    bus_arbiter_2dev #(.MAX_HOLD(2), .TURNAROUND(0), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_1(b_req_1), .req_2(b_req_2), .done_1(b_done_1), .done_2(b_done_2),
        .select(b_select), .gnt_1(b_gnt_1), .gnt_2(b_gnt_2),
        .bus_valid(b_bus_valid), .preempt(b_preempt)
    );

    always @(negedge clk) begin
        checks++;
        assert (!(a_gnt_1 && a_gnt_2) && !(b_gnt_1 && b_gnt_2)) else begin
            errors++;
            $display("FAIL mutex t=%0t a=%b%b b=%b%b required no double grant",
                     $time, a_gnt_1, a_gnt_2, b_gnt_1, b_gnt_2);
        end
    end

    function automatic logic [4:0] outs(input int dut);
        if (dut == 0) return {a_gnt_1, a_gnt_2, a_select, a_preempt, a_bus_valid};
        return {b_gnt_1, b_gnt_2, b_select, b_preempt, b_bus_valid};
    endfunction

    task automatic expect_push(input int dut, input logic [3:0] e);
        sb_t s;
        s.exp = {e, e[3] | e[2]};
        s.dut = dut;
        s.idx = vec_idx;
        sb.push_back(s);
    endtask

    task automatic compare_pop();
        sb_t s;
        logic [4:0] act;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty vec=%0d", vec_idx);
            return;
        end
        s = sb.pop_front();
        act = outs(s.dut);
        if (act !== s.exp) begin
            errors++;
            $display("FAIL dut%0d vec%0d {g1,g2,sel,pre,bv} got=%b required=%b",
                     s.dut, s.idx, act, s.exp);
        end
    endtask

    // b = {req_1, req_2, done_1, done_2, exp gnt_1, gnt_2, select, preempt}
    task automatic step(input int dut, input logic [7:0] b);
        if (dut == 0) {a_req_1, a_req_2, a_done_1, a_done_2} = b[7:4];
        else          {b_req_1, b_req_2, b_done_1, b_done_2} = b[7:4];
        expect_push(dut, b[3:0]);
        @(posedge clk);
        @(negedge clk);
        compare_pop();
        vec_idx++;
    endtask

    task automatic run_seq(input int dut);
        for (int i = 0; i < seq.size(); i++) step(dut, seq[i]);
        seq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        {a_req_1, a_req_2, a_done_1, a_done_2} = 4'b0000;
        {b_req_1, b_req_2, b_done_1, b_done_2} = 4'b0000;
        rst_n = 1'b0;
        #1;
        expect_push(0, 4'b0000); compare_pop();
        expect_push(1, 4'b0000); compare_pop();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single requester, done pulse, stray done pulses ignored.
        seq = '{8'b1000_1000, 8'b1000_1000, 8'b1000_1000, 8'b1000_1000,
                8'b1010_0000, 8'b0000_0000, 8'b0010_0000,
                8'b1000_1000, 8'b1001_1000, 8'b1000_1000,
                8'b0000_0000, 8'b0000_0000};
        run_seq(0);

        // Contention: hold limit, preempt pulse, one-cycle gaps, alternation.
        do_reset();
        for (int i = 0; i < 4; i++) seq.push_back(8'b1100_1000);
        seq.push_back(8'b1100_0001);
        for (int i = 0; i < 4; i++) seq.push_back(8'b1100_0110);
        seq.push_back(8'b1100_0011);
        seq.push_back(8'b1100_1000);
        seq.push_back(8'b0000_0000);
        seq.push_back(8'b0000_0000);
        run_seq(0);

        // Lone requester keeps the bus without limit; select held through IDLE.
        for (int i = 0; i < 20; i++) seq.push_back(8'b0100_0110);
        seq.push_back(8'b0000_0010);
        seq.push_back(8'b0000_0010);
        run_seq(0);

        // done with req still high and other device arriving: release, no preempt.
        seq = '{8'b1000_1000, 8'b1000_1000, 8'b1100_1000, 8'b1110_0000,
                8'b1100_0110, 8'b1101_0010, 8'b1000_1000,
                8'b0000_0000, 8'b0000_0000};
        run_seq(0);

        // Asynchronous reset in the middle of a device-2 tenure.
        do_reset();
        step(0, 8'b0100_0110);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_push(0, 4'b0000);
        compare_pop();
        @(negedge clk);
        a_req_1 = 1'b1;
        rst_n = 1'b1;
        step(0, 8'b1100_1000);
        step(0, 8'b1100_1000);

        // No turnaround, hold 2: back-to-back swaps every two cycles.
        do_reset();
        seq = '{8'b1100_1000, 8'b1100_1000, 8'b1100_0111, 8'b1100_0110,
                8'b1100_1001, 8'b1100_1000, 8'b1100_0111, 8'b0000_0010};
        run_seq(1);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d required=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
